// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: one-hot
// result codes, FSM state encoding and the cascade seed normaliser.
package cmp_pkg;

    // One-hot compare result codes.
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    // Controller state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Any seed that is not one of the three legal one-hot codes collapses to
    // "equal", so a floating or corrupted cascade input cannot bias a result.
    function automatic logic [2:0] normSeed(input logic [2:0] seed);
        logic [2:0] result;
        case (seed)
            CMP_GT:  result = CMP_GT;
            CMP_LT:  result = CMP_LT;
            default: result = CMP_EQ;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cmp_chunk_stage.sv
// One combinational slice of the comparator: compares a CHUNK-bit pair and
// either overrides the prior result (chunks differ) or passes it through.
module cmp_chunk_stage
    import cmp_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             isSigned,
    input  logic [2:0]       prior,
    output logic [2:0]       result
);

    logic aGreater;

    // Ordering of the chunk pair; the signed view is only requested for the
    // chunk that carries the operand sign bit.
    always_comb begin
        aGreater = 1'b0;
        if (isSigned) begin
            aGreater = ($signed(a) > $signed(b));
        end else begin
            aGreater = (a > b);
        end
    end

    // A differing chunk decides the result outright; an equal one defers to
    // whatever the less significant chunks (or the seed) already decided.
    always_comb begin
        result = prior;
        if (a != b) begin
            result = aGreater ? CMP_GT : CMP_LT;
        end
    end

endmodule

// File: rtl/seq_data_compare.sv
// Multi-cycle magnitude comparator for wide operands. Operands are latched on
// request and walked CHUNK bits per clock, least significant chunk first, so
// each more significant chunk can override the running result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The requester holds iValid and its operands until oReady; the
// block holds oValid and oData until iReady. Neither side may retract valid
// before the transfer completes.
module seq_data_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic             iSigned,
    input  logic [2:0]       iData,
    output logic             oValid,
    input  logic             iReady,
    output logic [2:0]       oData,
    output logic             oBusy,
    output logic [1:0]       oState
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    // Reject parameter sets that would leave a partial top chunk.
    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_params
            $error("seq_data_compare: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [CNT_W-1:0] chunkCnt;
    logic [WIDTH-1:0] aShift;
    logic [WIDTH-1:0] bShift;
    logic             signedReg;
    logic [2:0]       runResult;
    logic [2:0]       dataReg;
    logic             validReg;
    logic             armed;

    logic             accept;
    logic             lastChunk;
    logic [2:0]       stageResult;

    // Ready only once the first clock after reset has been seen and the
    // controller is idle; this keeps at most one request in flight.
    assign oReady    = armed && (state == IDLE);
    assign accept    = iValid && oReady;
    assign lastChunk = (chunkCnt == LAST_CHUNK);

    assign oValid = validReg;
    assign oData  = dataReg;
    assign oBusy  = (state != IDLE);
    assign oState = state;

    // The latched operands shift right each RUN cycle, so the chunk under
    // test is always the low CHUNK bits; only the top chunk may be signed.
    cmp_chunk_stage #(
        .CHUNK (CHUNK)
    ) u_stage (
        .a        (aShift[CHUNK-1:0]),
        .b        (bShift[CHUNK-1:0]),
        .isSigned (signedReg && lastChunk),
        .prior    (runResult),
        .result   (stageResult)
    );

    // Controller: accept in IDLE, one chunk per cycle in RUN, present and
    // hold the result in DONE until the consumer takes it.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            chunkCnt  <= '0;
            aShift    <= '0;
            bShift    <= '0;
            signedReg <= 1'b0;
            runResult <= CMP_EQ;
            dataReg   <= CMP_EQ;
            validReg  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        aShift    <= iData_a;
                        bShift    <= iData_b;
                        signedReg <= iSigned;
                        runResult <= normSeed(iData);
                        chunkCnt  <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    runResult <= stageResult;
                    aShift    <= aShift >> CHUNK;
                    bShift    <= bShift >> CHUNK;
                    chunkCnt  <= chunkCnt + 1'b1;
                    if (lastChunk) begin
                        dataReg  <= stageResult;
                        validReg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        validReg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    validReg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_data_compare.sv
// Directed bench for seq_data_compare at WIDTH=16, CHUNK=4: checks reset
// values, latency, unsigned/signed ordering, seed pass-through, backpressure
// and reset in the middle of a compare.
module tb_seq_data_compare;
    import cmp_pkg::*;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             iClk = 1'b0;
    logic             iRst_n;
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic             iSigned;
    logic [2:0]       iData;
    logic             oValid;
    logic             iReady;
    logic [2:0]       oData;
    logic             oBusy;
    logic [1:0]       oState;

    int vec_count   = 0;
    int miscompares = 0;
    logic [2:0] exp_q[$];

    seq_data_compare #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iValid  (iValid),
        .oReady  (oReady),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iSigned (iSigned),
        .iData   (iData),
        .oValid  (oValid),
        .iReady  (iReady),
        .oData   (oData),
        .oBusy   (oBusy),
        .oState  (oState)
    );

    // Clock and watchdog.
    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full request/response; hold = extra cycles iReady stays low.
    task automatic run_compare(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic s,
                               input logic [2:0] seed, input logic [2:0] expected,
                               input int hold);
        int n;
        logic [2:0] exp_val;
        @(negedge iClk);
        iData_a = a;
        iData_b = b;
        iSigned = s;
        iData   = seed;
        iValid  = 1'b1;
        iReady  = 1'b0;
        n = 0;
        while (oReady !== 1'b1 && n < 20) begin
            @(negedge iClk);
            n++;
        end
        vec_count++;
        if (oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: oReady=%b required 1", name, oReady);
        end
        exp_q.push_back(expected);
        @(posedge iClk);
        @(negedge iClk);
        // Scramble the inputs: the latched copies must be used.
        iValid  = 1'b0;
        iData_a = ~a;
        iData_b = ~b;
        iSigned = ~s;
        iData   = 3'b000;
        vec_count++;
        if (oBusy !== 1'b1 || oReady !== 1'b0) begin
            miscompares++;
            $display("FAIL %s run: oBusy=%b oReady=%b required 1/0", name, oBusy, oReady);
        end
        repeat (NCHUNK - 1) @(negedge iClk);
        vec_count++;
        if (oValid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early_valid: oValid=%b required 0", name, oValid);
        end
        @(negedge iClk);
        vec_count++;
        if (oValid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s latency: oValid=%b required 1", name, oValid);
        end
        exp_val = exp_q.pop_front();
        vec_count++;
        if (oData !== exp_val) begin
            miscompares++;
            $display("FAIL %s result: oData=%b required %b", name, oData, exp_val);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge iClk);
            vec_count++;
            if (oValid !== 1'b1 || oData !== exp_val || oReady !== 1'b0) begin
                miscompares++;
                $display("FAIL %s hold%0d: oValid=%b oData=%b oReady=%b required 1/%b/0",
                         name, i, oValid, oData, oReady, exp_val);
            end
        end
        iReady = 1'b1;
        @(negedge iClk);
        iReady = 1'b0;
        vec_count++;
        if (oValid !== 1'b0 || oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL %s release: oValid=%b oReady=%b required 0/1", name, oValid, oReady);
        end
    endtask

    task automatic test_reset();
        iRst_n  = 1'b0;
        iValid  = 1'b0;
        iReady  = 1'b0;
        iData_a = '0;
        iData_b = '0;
        iSigned = 1'b0;
        iData   = CMP_EQ;
        #12;
        vec_count++;
        if (oValid !== 1'b0 || oData !== 3'b010 || oBusy !== 1'b0 || oState !== IDLE) begin
            miscompares++;
            $display("FAIL reset_values: oValid=%b oData=%b oBusy=%b oState=%0d required 0/010/0/0",
                     oValid, oData, oBusy, oState);
        end
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        vec_count++;
        if (oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: oReady=%b required 1", oReady);
        end
    endtask

    task automatic test_unsigned();
        run_compare("uns_gt",      16'h1234, 16'h1233, 1'b0, 3'b010, 3'b100, 0);
        run_compare("uns_gt_seed", 16'h1234, 16'h1233, 1'b0, 3'b001, 3'b100, 0);
        run_compare("override_gt", 16'h2001, 16'h1FFF, 1'b0, 3'b010, 3'b100, 0);
        run_compare("override_lt", 16'h1FFF, 16'h2001, 1'b0, 3'b010, 3'b001, 0);
    endtask

    task automatic test_signed();
        run_compare("sgn_neg_lt",  16'h8000, 16'h0001, 1'b1, 3'b010, 3'b001, 0);
        run_compare("uns_same_gt", 16'h8000, 16'h0001, 1'b0, 3'b010, 3'b100, 0);
        run_compare("sgn_m1_gt",   16'hFFFF, 16'h8000, 1'b1, 3'b010, 3'b100, 0);
        run_compare("sgn_topeq",   16'h8001, 16'h8002, 1'b1, 3'b010, 3'b001, 0);
    endtask

    task automatic test_seed();
        run_compare("seed_gt",  16'hBEEF, 16'hBEEF, 1'b0, 3'b100, 3'b100, 0);
        run_compare("seed_lt",  16'hBEEF, 16'hBEEF, 1'b0, 3'b001, 3'b001, 0);
        run_compare("seed_bad", 16'hBEEF, 16'hBEEF, 1'b0, 3'b111, 3'b010, 0);
        run_compare("seed_eq",  16'hBEEF, 16'hBEEF, 1'b1, 3'b010, 3'b010, 0);
    endtask

    task automatic test_backpressure();
        run_compare("backpressure", 16'h0005, 16'h0007, 1'b0, 3'b010, 3'b001, 5);
    endtask

    task automatic test_reset_mid_run();
        @(negedge iClk);
        iData_a = 16'hF000;
        iData_b = 16'h0001;
        iSigned = 1'b0;
        iData   = CMP_EQ;
        iValid  = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        repeat (2) @(negedge iClk);
        vec_count++;
        if (oBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_busy: oBusy=%b required 1", oBusy);
        end
        iRst_n = 1'b0;
        #1;
        vec_count++;
        if (oValid !== 1'b0 || oData !== 3'b010 || oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: oValid=%b oData=%b oBusy=%b required 0/010/0",
                     oValid, oData, oBusy);
        end
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        vec_count++;
        if (oReady !== 1'b1 || oValid !== 1'b0 || oData !== 3'b010) begin
            miscompares++;
            $display("FAIL midrun_release: oReady=%b oValid=%b oData=%b required 1/0/010",
                     oReady, oValid, oData);
        end
        run_compare("after_reset", 16'h0100, 16'h00FF, 1'b0, 3'b010, 3'b100, 0);
    endtask

    task automatic test_back_to_back();
        run_compare("b2b_0", 16'h0000, 16'hFFFF, 1'b0, 3'b010, 3'b001, 0);
        run_compare("b2b_1", 16'h0000, 16'hFFFF, 1'b1, 3'b010, 3'b100, 0);
        run_compare("b2b_2", 16'h7FFF, 16'h7FFE, 1'b1, 3'b001, 3'b100, 0);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_seed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
